core_wb_data_bridge: RTL and testbench
======================================

Name: core_wb_data_bridge

Overview:
Registered, parametrised bridge between the core's simple data-memory port (req/stall/err, active-low write enable) and a Wishbone B4 pipelined master. It replaces the combinational data-side glue of the Wishbone core wrapper. It adds:
- a request capture register,
- an explicit FSM with one outstanding transaction,
- configurable data/address width,
- a bus watchdog timeout that converts a hung slave into a core access error,
- a sticky error-cause report.

Parameters:
ADDR_W, 32, address width of core and Wishbone side
DATA_W, 32, data width; multiple of 8; SEL_W = DATA_W/8
TIMEOUT, 255, cycles allowed from first stb cycle to ack/err; 0 disables the watchdog

Ports:
data_wb_clk_i  in  1  clock
data_wb_rst_i  in  1  reset, asynchronous, active-high
core_req_i  in  1  core access request, held by core while core_stall_o=1
core_wen_ni  in  1  core write enable, active-low (0=write)
core_addr_i  in  ADDR_W  core address
core_wdata_i  in  DATA_W  core write data
core_wmask_i  in  SEL_W  core byte mask
core_rdata_o  out  DATA_W  read data, valid in DONE
core_stall_o  out  1  core must hold request
core_err_o  out  1  access error, valid in DONE
data_wb_cyc_o  out  1  WB cycle
data_wb_stb_o  out  1  WB strobe
data_wb_we_o  out  1  WB write enable
data_wb_adr_o  out  ADDR_W  WB address
data_wb_dat_o  out  DATA_W  WB write data
data_wb_sel_o  out  SEL_W  WB byte select
data_wb_stall_i  in  1  WB slave stall
data_wb_ack_i  in  1  WB acknowledge
data_wb_dat_i  in  DATA_W  WB read data
data_wb_err_i  in  1  WB error
err_cause_o  out  2  sticky: 00 none, 01 bus err, 10 timeout; updated at each completion

Behaviour:
- Reset (async, data_wb_rst_i=1):
  - State goes to IDLE.
  - cyc, stb, we, adr, dat_o, sel, core_rdata_o, core_err_o, err_cause_o and the timeout counter all go to 0.
  - A transaction in flight is abandoned with no response to the core.
- FSM states: IDLE, BUS, WAIT, DONE.
- IDLE:
  - cyc=stb=0.
  - core_stall_o = core_req_i (combinational).
  - If core_req_i=1: capture adr, dat, sel, we=~core_wen_ni into registers; clear the counter; go to BUS.
- BUS:
  - cyc=stb=1; drive the registered fields; core_stall_o=1.
  - If data_wb_stall_i=0, the request is accepted.
  - ack_i or err_i in the same cycle as acceptance: go to DONE.
  - Otherwise, on acceptance: go to WAIT.
  - While stalled: stay in BUS.
- WAIT:
  - cyc=1, stb=0, core_stall_o=1.
  - On ack_i or err_i: go to DONE.
- Watchdog:
  - The counter increments in every BUS/WAIT cycle without ack/err.
  - If TIMEOUT>0 and the counter reaches TIMEOUT-1 with no ack/err in that cycle, go to DONE as a timeout, dropping cyc/stb.
  - Total bus-occupancy limit is TIMEOUT cycles.
- Capture in the transition to DONE:
  - core_rdata_o <= data_wb_dat_i on ack (reads and writes); unchanged on error or timeout.
  - core_err_o <= err_i | timeout.
  - err_cause_o <= 01 if err_i (err_i has priority over ack_i if both are high), 10 on timeout, 00 on ack.
- DONE:
  - cyc=stb=0, core_stall_o=0; lasts exactly 1 cycle; core_rdata_o and core_err_o are valid.
  - core_req_i is ignored (it is the retiring request); go to IDLE.
  - core_err_o returns to 0 when leaving DONE.
- Minimum latency for a zero-wait slave: IDLE(req) -> BUS(ack) -> DONE. Stall is visible for 2 cycles, and the core completes on the 3rd.
- Stray ack_i/err_i in IDLE or DONE is ignored.
- Registered WB fields hold their values outside BUS/WAIT.
- The watchdog counter width is clog2(TIMEOUT+1); it never wraps (saturates at terminal count).

Test Plan:
- Zero-wait read: req, addr=0x100, wen_n=1; slave ack in the first stb cycle with dat=0xDEADBEEF -> stb high 1 cycle; DONE in cycle 2 with rdata=0xDEADBEEF, err=0, stall pattern 1,1,0.
- Stalled write: wen_n=0, wdata=0x12345678, mask=4'b0011; slave stall_i=1 for 3 cycles, then ack 2 cycles later -> stb high 4 cycles with we=1, sel=0011; cyc high until ack; single DONE cycle, err_cause=00.
- Bus error: err_i=1 and ack_i=1 together in WAIT -> core_err_o=1 for one cycle, err_cause=01, rdata unchanged.
- Timeout, TIMEOUT=8: slave never responds -> cyc drops after exactly 8 bus cycles, core_err_o=1 in DONE, err_cause=10; a late ack in IDLE causes no state change. With TIMEOUT=0, the bridge waits indefinitely for 1000 cycles.
- Reset mid-WAIT: assert data_wb_rst_i asynchronously -> cyc/stb drop immediately, all outputs 0, state IDLE; the next request completes normally.
- Back-to-back: core_req_i held high across DONE and into the next IDLE -> the second access starts in the IDLE cycle after DONE, with no duplicate issue during DONE.

Source files
------------

// File: rtl/core_wb_data_bridge.sv
// ---------------------------------------------------------------------------
// core_wb_data_bridge
//
// Purpose:
//   Registered bridge from the core's data-memory port (req / stall / err,
//   active-low write enable) to a Wishbone B4 pipelined master. It keeps one
//   transaction outstanding at a time. A watchdog turns a hung slave into a
//   core access error, and a sticky two-bit code records why the most recent
//   access finished.
//
// Ports:
//   data_wb_clk_i / data_wb_rst_i : clock, asynchronous active-high reset
//   core_req_i, core_wen_ni       : core request, write enable (0 = write)
//   core_addr_i, core_wdata_i     : core address and write data
//   core_wmask_i                  : core byte mask
//   core_rdata_o, core_err_o      : response data and error, valid in DONE
//   core_stall_o                  : core must hold its request while high
//   data_wb_cyc_o/stb_o/we_o      : Wishbone cycle, strobe, write enable
//   data_wb_adr_o/dat_o/sel_o     : Wishbone address, write data, byte select
//   data_wb_stall_i/ack_i/err_i   : Wishbone slave stall, ack, error
//   data_wb_dat_i                 : Wishbone read data
//   err_cause_o                   : 00 none, 01 bus error, 10 timeout
// ---------------------------------------------------------------------------
module core_wb_data_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  localparam int SEL_W  = DATA_W / 8
) (
  input  logic              data_wb_clk_i,
  input  logic              data_wb_rst_i,
  input  logic              core_req_i,
  input  logic              core_wen_ni,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  input  logic [SEL_W-1:0]  core_wmask_i,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_stall_o,
  output logic              core_err_o,
  output logic              data_wb_cyc_o,
  output logic              data_wb_stb_o,
  output logic              data_wb_we_o,
  output logic [ADDR_W-1:0] data_wb_adr_o,
  output logic [DATA_W-1:0] data_wb_dat_o,
  output logic [SEL_W-1:0]  data_wb_sel_o,
  input  logic              data_wb_stall_i,
  input  logic              data_wb_ack_i,
  input  logic [DATA_W-1:0] data_wb_dat_i,
  input  logic              data_wb_err_i,
  output logic [1:0]        err_cause_o
);

  // When the watchdog is disabled, a one-bit counter is kept so the widths
  // stay legal. It never advances because its saturation value is zero.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_WAIT, S_DONE} state_t;

  state_t            state_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] adr_reg;
  logic [DATA_W-1:0] dat_reg;
  logic [SEL_W-1:0]  sel_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;
  logic [1:0]        cause_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic in_bus;
  logic in_wait;
  logic resp_valid;
  logic timeout_hit;

  assign in_bus  = (state_reg == S_BUS);
  assign in_wait = (state_reg == S_WAIT);

  // A response counts only once the strobe has been accepted. With a single
  // outstanding request, ack/err during a stalled strobe is not ours.
  assign resp_valid = ((in_bus & ~data_wb_stall_i) | in_wait) &
                      (data_wb_ack_i | data_wb_err_i);

  // The counter starts at 0 in the first strobe cycle. Firing at TIMEOUT-1
  // therefore caps bus occupancy at TIMEOUT cycles.
  assign timeout_hit = (TIMEOUT > 0) && (in_bus || in_wait) && !resp_valid &&
                       (cnt_reg == CNT_LAST);

  always_ff @(posedge data_wb_clk_i or posedge data_wb_rst_i) begin
    if (data_wb_rst_i) begin
      state_reg <= S_IDLE;
      we_reg    <= 1'b0;
      adr_reg   <= '0;
      dat_reg   <= '0;
      sel_reg   <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      cause_reg <= 2'b00;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (core_req_i) begin
            adr_reg   <= core_addr_i;
            dat_reg   <= core_wdata_i;
            sel_reg   <= core_wmask_i;
            we_reg    <= ~core_wen_ni;
            cnt_reg   <= '0;
            state_reg <= S_BUS;
          end
        end
        S_BUS, S_WAIT: begin
          if (resp_valid) begin
            // An error wins over a simultaneous ack. Read data is kept on error.
            state_reg <= S_DONE;
            err_reg   <= data_wb_err_i;
            cause_reg <= data_wb_err_i ? 2'b01 : 2'b00;
            if (!data_wb_err_i) begin
              rdata_reg <= data_wb_dat_i;
            end
          end else if (timeout_hit) begin
            state_reg <= S_DONE;
            err_reg   <= 1'b1;
            cause_reg <= 2'b10;
          end else begin
            if (cnt_reg != CNT_MAX) begin
              cnt_reg <= cnt_reg + 1'b1;
            end
            if (in_bus && !data_wb_stall_i) begin
              state_reg <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          // The request still present here is the retiring one, so ignore it.
          err_reg   <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    core_stall_o = 1'b0;
    case (state_reg)
      S_IDLE:         core_stall_o = core_req_i;
      S_BUS, S_WAIT:  core_stall_o = 1'b1;
      default:        core_stall_o = 1'b0;
    endcase
  end

  assign data_wb_cyc_o = in_bus | in_wait;
  assign data_wb_stb_o = in_bus;
  assign data_wb_we_o  = we_reg;
  assign data_wb_adr_o = adr_reg;
  assign data_wb_dat_o = dat_reg;
  assign data_wb_sel_o = sel_reg;
  assign core_rdata_o  = rdata_reg;
  assign core_err_o    = err_reg;
  assign err_cause_o   = cause_reg;

endmodule

// File: tb/tb_core_wb_data_bridge.sv
// ---------------------------------------------------------------------------
// tb_core_wb_data_bridge
//
// Purpose:
//   Directed self-checking bench for core_wb_data_bridge. Instance dut has
//   TIMEOUT=8. Instance dut0 has the watchdog disabled (TIMEOUT=0) and its own
//   request line. Both instances share the other core-side and slave-side
//   inputs.
// ---------------------------------------------------------------------------
module tb_core_wb_data_bridge;

  logic        clk;
  logic        rst;
  logic        req;
  logic        req0;
  logic        wen_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        s_stall;
  logic        s_ack;
  logic        s_err;
  logic [31:0] s_dat;

  logic [31:0] rdata;
  logic        stall;
  logic        err;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [3:0]  sel;
  logic [1:0]  cause;

  logic [31:0] rdata0;
  logic        stall0;
  logic        err0;
  logic        cyc0;
  logic        stb0;
  logic        we0;
  logic [31:0] adr0;
  logic [31:0] dat_o0;
  logic [3:0]  sel0;
  logic [1:0]  cause0;

  int n_cmp;
  int n_bad;

  core_wb_data_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .data_wb_clk_i   (clk),
    .data_wb_rst_i   (rst),
    .core_req_i      (req),
    .core_wen_ni     (wen_n),
    .core_addr_i     (addr),
    .core_wdata_i    (wdata),
    .core_wmask_i    (wmask),
    .core_rdata_o    (rdata),
    .core_stall_o    (stall),
    .core_err_o      (err),
    .data_wb_cyc_o   (cyc),
    .data_wb_stb_o   (stb),
    .data_wb_we_o    (we),
    .data_wb_adr_o   (adr),
    .data_wb_dat_o   (dat_o),
    .data_wb_sel_o   (sel),
    .data_wb_stall_i (s_stall),
    .data_wb_ack_i   (s_ack),
    .data_wb_dat_i   (s_dat),
    .data_wb_err_i   (s_err),
    .err_cause_o     (cause)
  );

  core_wb_data_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut0 (
    .data_wb_clk_i   (clk),
    .data_wb_rst_i   (rst),
    .core_req_i      (req0),
    .core_wen_ni     (wen_n),
    .core_addr_i     (addr),
    .core_wdata_i    (wdata),
    .core_wmask_i    (wmask),
    .core_rdata_o    (rdata0),
    .core_stall_o    (stall0),
    .core_err_o      (err0),
    .data_wb_cyc_o   (cyc0),
    .data_wb_stb_o   (stb0),
    .data_wb_we_o    (we0),
    .data_wb_adr_o   (adr0),
    .data_wb_dat_o   (dat_o0),
    .data_wb_sel_o   (sel0),
    .data_wb_stall_i (s_stall),
    .data_wb_ack_i   (s_ack),
    .data_wb_dat_i   (s_dat),
    .data_wb_err_i   (s_err),
    .err_cause_o     (cause0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    req     = 1'b0;
    req0    = 1'b0;
    wen_n   = 1'b1;
    addr    = '0;
    wdata   = '0;
    wmask   = '0;
    s_stall = 1'b0;
    s_ack   = 1'b0;
    s_err   = 1'b0;
    s_dat   = '0;
    tick();
    tick();
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_adr", adr, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err, 0);
    check("rst_cause", cause, 0);
    rst = 1'b0;
    tick();

    // Zero-wait read
    req = 1'b1; wen_n = 1'b1; addr = 32'h100;
    #1 check("zw_stall_idle", stall, 1);
    check("zw_cyc_idle", cyc, 0);
    tick();
    check("zw_stb_bus", stb, 1);
    check("zw_we_bus", we, 0);
    check("zw_adr_bus", adr, 32'h100);
    check("zw_stall_bus", stall, 1);
    s_ack = 1'b1; s_dat = 32'hDEADBEEF;
    tick();
    s_ack = 1'b0;
    check("zw_stall_done", stall, 0);
    check("zw_stb_done", stb, 0);
    check("zw_rdata", rdata, 32'hDEADBEEF);
    check("zw_err", err, 0);
    req = 1'b0;
    tick();
    check("zw_cyc_idle2", cyc, 0);

    // Stalled write: three stalled strobe cycles, then acceptance, then ack
    // two cycles after acceptance.
    req = 1'b1; wen_n = 1'b0; addr = 32'h200; wdata = 32'h12345678; wmask = 4'b0011;
    s_stall = 1'b1;
    tick();
    check("sw_we", we, 1);
    check("sw_sel", sel, 4'b0011);
    check("sw_dat", dat_o, 32'h12345678);
    n = 1;
    tick(); if (stb) n++;
    tick(); if (stb) n++;
    tick(); if (stb) n++;
    s_stall = 1'b0;
    tick();
    check("sw_stb_cycles", n, 4);
    check("sw_stb_wait", stb, 0);
    check("sw_cyc_wait", cyc, 1);
    tick();
    check("sw_cyc_wait2", cyc, 1);
    s_ack = 1'b1; s_dat = 32'hA5A5A5A5;
    tick();
    s_ack = 1'b0;
    check("sw_cyc_done", cyc, 0);
    check("sw_cause", cause, 0);
    check("sw_err", err, 0);
    check("sw_rdata", rdata, 32'hA5A5A5A5);
    req = 1'b0;
    tick();
    check("sw_single_done", stall, 0);

    // Bus error with a simultaneous ack while waiting
    req = 1'b1; wen_n = 1'b1; addr = 32'h300;
    tick();
    tick();
    check("be_wait_cyc", cyc, 1);
    s_err = 1'b1; s_ack = 1'b1; s_dat = 32'h11111111;
    tick();
    s_err = 1'b0; s_ack = 1'b0;
    check("be_err", err, 1);
    check("be_cause", cause, 2'b01);
    check("be_rdata_kept", rdata, 32'hA5A5A5A5);
    req = 1'b0;
    tick();
    check("be_err_clear", err, 0);
    check("be_cause_sticky", cause, 2'b01);

    // Timeout with TIMEOUT=8: the slave never answers
    req = 1'b1; addr = 32'h400;
    tick();
    n = 0;
    while (cyc && n < 20) begin
      n++;
      tick();
    end
    check("to_bus_cycles", n, 8);
    check("to_err", err, 1);
    check("to_cause", cause, 2'b10);
    check("to_rdata_kept", rdata, 32'hA5A5A5A5);
    req = 1'b0;
    tick();
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    check("to_late_ack_cyc", cyc, 0);
    check("to_late_ack_err", err, 0);
    check("to_late_ack_stall", stall, 0);

    // Watchdog disabled: waits for 1000 cycles, then completes on ack
    req0 = 1'b1; addr = 32'h500;
    tick();
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (cyc0) n++;
      tick();
    end
    check("nt_cyc_held", n, 1000);
    check("nt_still_cyc", cyc0, 1);
    s_ack = 1'b1; s_dat = 32'hCAFEF00D;
    tick();
    s_ack = 1'b0;
    check("nt_err", err0, 0);
    check("nt_rdata", rdata0, 32'hCAFEF00D);
    check("nt_stall_done", stall0, 0);
    req0 = 1'b0;
    tick();

    // Asynchronous reset while waiting
    req = 1'b1; addr = 32'h600;
    tick();
    tick();
    check("rw_cyc_before", cyc, 1);
    req = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("rw_cyc", cyc, 0);
    check("rw_stb", stb, 0);
    check("rw_adr", adr, 0);
    check("rw_rdata", rdata, 0);
    check("rw_cause", cause, 0);
    check("rw_stall", stall, 0);
    tick();
    rst = 1'b0;
    tick();
    req = 1'b1; addr = 32'h700;
    tick();
    check("rw_next_adr", adr, 32'h700);
    s_ack = 1'b1; s_dat = 32'h55AA55AA;
    tick();
    s_ack = 1'b0;
    check("rw_next_rdata", rdata, 32'h55AA55AA);
    check("rw_next_err", err, 0);

    // Back-to-back: the request stays high through DONE
    addr = 32'h804;
    tick();
    check("bb_idle_stall", stall, 1);
    check("bb_idle_cyc", cyc, 0);
    tick();
    check("bb_bus_adr", adr, 32'h804);
    s_ack = 1'b1; s_dat = 32'h00000001;
    tick();
    s_ack = 1'b0;
    check("bb_done1_rdata", rdata, 32'h1);
    addr = 32'h808;
    check("bb_done1_cyc", cyc, 0);
    tick();
    check("bb_idle2_stall", stall, 1);
    tick();
    check("bb_bus2_adr", adr, 32'h808);
    s_ack = 1'b1; s_dat = 32'h00000002;
    tick();
    s_ack = 1'b0;
    check("bb_done2_rdata", rdata, 32'h2);
    req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
